// File: rtl/sopc_run_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sopc_run_ctrl_pkg
//   Shared types and constants for the SOPC run controller.
//   - state_e    : FSM state encoding (HOLD / RUN / DONE), exposed on state_o
//   - exit_t     : exit reason encoding, exposed on exit_o
//   - cnt_width(): width of a counter that must hold values 0..n-1 (min 1 bit)
// -----------------------------------------------------------------------------
package sopc_run_ctrl_pkg;

  localparam int STATE_W = 2;
  localparam int EXIT_W  = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef logic [EXIT_W-1:0] exit_t;

  localparam exit_t EXIT_NONE    = 2'd0;
  localparam exit_t EXIT_HALT    = 2'd1;
  localparam exit_t EXIT_STALL   = 2'd2;
  localparam exit_t EXIT_TIMEOUT = 2'd3;

  // Bits needed to count 0..n-1; never less than one bit so that degenerate
  // parameter values still give a legal vector.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sopc_run_ctrl_stall_det.sv
// -----------------------------------------------------------------------------
// sopc_run_ctrl_stall_det
//   Detects a core spinning on one fetch PC (a self-loop such as "j ."). It
//   remembers the last valid PC and counts consecutive valid fetches of that
//   same PC. stall_hit_o is a combinational pulse, high in the RUN cycle in
//   which the repeat counter would reach STALL_LIMIT; the parent registers it.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   run_i        in   parent FSM is in RUN; tracking only happens then
//   clear_i      in   synchronous clear of counter and pc_seen (run restart)
//   pc_i         in   core fetch PC
//   pc_valid_i   in   pc_i is meaningful this cycle; invalid cycles are ignored
//                     entirely (no count, no PC capture)
//   stall_hit_o  out  stall exit condition for this cycle
//
// Parameters
//   PC_W         PC width
//   STALL_LIMIT  repeated-PC cycles that trigger a hit; 0 disables the hit
// -----------------------------------------------------------------------------
module sopc_run_ctrl_stall_det
  import sopc_run_ctrl_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_i,
  input  logic            clear_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic            pc_valid_i,
  output logic            stall_hit_o
);

  // Counter holds 0..STALL_LIMIT.
  localparam int unsigned SW        = cnt_width(STALL_LIMIT + 1);
  localparam logic [SW:0] LIMIT_EXT = (SW + 1)'(STALL_LIMIT);
  localparam bit          LIMIT_EN  = (STALL_LIMIT != 0);
  localparam logic [SW-1:0] CNT_MAX = '1;

  logic [PC_W-1:0] pc_last_q, pc_last_d;
  logic            pc_seen_q, pc_seen_d;
  logic [SW-1:0]   cnt_q, cnt_d;

  logic            is_repeat;
  logic [SW:0]     cnt_inc;

  assign is_repeat = pc_valid_i && pc_seen_q && (pc_i == pc_last_q);
  // One extra bit so the "would reach" compare cannot wrap.
  assign cnt_inc   = {1'b0, cnt_q} + (SW + 1)'(1);

  assign stall_hit_o = LIMIT_EN && run_i && is_repeat && (cnt_inc == LIMIT_EXT);

  always_comb begin
    pc_last_d = pc_last_q;
    pc_seen_d = pc_seen_q;
    cnt_d     = cnt_q;
    if (clear_i) begin
      // pc_last is left alone: pc_seen = 0 already forces a fresh capture.
      pc_seen_d = 1'b0;
      cnt_d     = '0;
    end else if (run_i && pc_valid_i) begin
      if (is_repeat) begin
        // Saturate so a disabled limit (0) cannot wrap into a false count.
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc[SW-1:0];
      end else begin
        pc_last_d = pc_i;
        pc_seen_d = 1'b1;
        cnt_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_last_q <= '0;
      pc_seen_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pc_last_q <= pc_last_d;
      pc_seen_q <= pc_seen_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/sopc_run_ctrl.sv
// -----------------------------------------------------------------------------
// sopc_run_ctrl
//   Run controller for the SOPC simulation / FPGA harness. Holds the SOPC in
//   reset for RST_HOLD cycles, then counts RUN cycles until the first of:
//   software halt, PC self-loop stall, or cycle-limit timeout. The exit
//   reason and halt code are latched and stay frozen in DONE until restart.
//
// Build option
//   SOPC_RUN_CTRL_STALL_DET_EN  when defined, the PC stall detector is built
//                               and exit reason 2 (stall) becomes possible.
//                               When undefined, pc_i / pc_valid_i are unused.
//
// Ports
//   clk          in   clock
//   reset        in   asynchronous active-low reset
//   restart_i    in   synchronous restart, any state, highest priority
//   pc_i         in   core fetch PC (PC_W)
//   pc_valid_i   in   pc_i valid this cycle (single-cycle qualifier, no
//                     back-pressure: every valid cycle is consumed)
//   halt_req_i   in   software halt request
//   halt_code_i  in   8-bit code latched with a halt
//   core_rst_o   out  active-high reset to the SOPC
//   cycle_o      out  RUN cycle count (CYC_W), saturating
//   done_o       out  sticky run-finished flag
//   exit_o       out  0 none, 1 halt, 2 stall, 3 timeout
//   code_o       out  latched halt code, 0 for non-halt exits
//   state_o      out  FSM state: 0 HOLD, 1 RUN, 2 DONE
//
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module sopc_run_ctrl
  import sopc_run_ctrl_pkg::*;
#(
  parameter int unsigned CYC_W       = 23,
  parameter int unsigned MAX_CYCLES  = 800,
  parameter int unsigned RST_HOLD    = 10,
  parameter int unsigned STALL_LIMIT = 16,
  parameter int unsigned PC_W        = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               pc_valid_i,
  input  logic               halt_req_i,
  input  logic [7:0]         halt_code_i,
  output logic               core_rst_o,
  output logic [CYC_W-1:0]   cycle_o,
  output logic               done_o,
  output logic [EXIT_W-1:0]  exit_o,
  output logic [7:0]         code_o,
  output logic [STATE_W-1:0] state_o
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (64'(MAX_CYCLES) > ((64'd1 << CYC_W) - 64'd1)) begin : g_bad_max_cycles
    $error("sopc_run_ctrl: MAX_CYCLES does not fit in CYC_W bits");
  end
  if (RST_HOLD < 1) begin : g_bad_rst_hold
    $error("sopc_run_ctrl: RST_HOLD must be at least 1");
  end

  localparam int unsigned     HOLD_W    = cnt_width(RST_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
  localparam logic [CYC_W-1:0] CYC_MAX   = '1;
  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
  localparam bit               TIMEOUT_EN = (MAX_CYCLES != 0);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,    state_d;
  logic              core_rst_q, core_rst_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CYC_W-1:0]  cycle_q,    cycle_d;
  logic              done_q,     done_d;
  exit_t             exit_q,     exit_d;
  logic [7:0]        code_q,     code_d;

  logic              run_active;
  logic              stall_hit;
  logic              timeout_hit;
  logic [CYC_W-1:0]  cycle_inc;

  assign run_active = (state_q == ST_RUN);

  // Saturating increment; the exit edge also loads this value, so a timeout
  // leaves cycle_o reading exactly MAX_CYCLES.
  assign cycle_inc   = (cycle_q == CYC_MAX) ? cycle_q : cycle_q + CYC_W'(1);
  assign timeout_hit = TIMEOUT_EN && (cycle_inc == CYC_LIMIT);

  // ---------------------------------------------------------------------------
  // Optional stall detector
  // ---------------------------------------------------------------------------
`ifdef SOPC_RUN_CTRL_STALL_DET_EN
  sopc_run_ctrl_stall_det #(
    .PC_W        (PC_W),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_det (
    .clk         (clk),
    .reset       (reset),
    .run_i       (run_active),
    .clear_i     (restart_i),
    .pc_i        (pc_i),
    .pc_valid_i  (pc_valid_i),
    .stall_hit_o (stall_hit)
  );
`else
  logic unused_pc;
  assign stall_hit = 1'b0;
  assign unused_pc = ^{pc_i, pc_valid_i};
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    core_rst_d = core_rst_q;
    hold_cnt_d = hold_cnt_q;
    cycle_d    = cycle_q;
    done_d     = done_q;
    exit_d     = exit_q;
    code_d     = code_q;

    if (restart_i) begin
      // Restart beats every exit condition raised in the same cycle.
      state_d    = ST_HOLD;
      core_rst_d = 1'b1;
      hold_cnt_d = '0;
      cycle_d    = '0;
      done_d     = 1'b0;
      exit_d     = EXIT_NONE;
      code_d     = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          core_rst_d = 1'b1;
          if (hold_cnt_q == HOLD_LAST) begin
            // core_rst falls on the same edge that enters RUN.
            state_d    = ST_RUN;
            core_rst_d = 1'b0;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end

        ST_RUN: begin
          core_rst_d = 1'b0;
          cycle_d    = cycle_inc;
          // Priority: halt > stall > timeout.
          if (halt_req_i) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            exit_d  = EXIT_HALT;
            code_d  = halt_code_i;
          end else if (stall_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            exit_d  = EXIT_STALL;
            code_d  = '0;
          end else if (timeout_hit) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            exit_d  = EXIT_TIMEOUT;
            code_d  = '0;
          end
        end

        ST_DONE: begin
          // Sticky; results frozen, halt requests ignored.
          core_rst_d = 1'b0;
        end

        default: begin
          // Unused encoding: recover through a fresh reset sequence.
          state_d    = ST_HOLD;
          core_rst_d = 1'b1;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_HOLD;
      core_rst_q <= 1'b1;
      hold_cnt_q <= '0;
      cycle_q    <= '0;
      done_q     <= 1'b0;
      exit_q     <= EXIT_NONE;
      code_q     <= '0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      hold_cnt_q <= hold_cnt_d;
      cycle_q    <= cycle_d;
      done_q     <= done_d;
      exit_q     <= exit_d;
      code_q     <= code_d;
    end
  end

  assign core_rst_o = core_rst_q;
  assign cycle_o    = cycle_q;
  assign done_o     = done_q;
  assign exit_o     = exit_q;
  assign code_o     = code_q;
  assign state_o    = state_q;

endmodule
